edge_event_arbiter: RTL and testbench

// - Multi-channel edge-event front end: synchronises N_CH async level inputs, detects edges per channel
//   and latches each edge as a pending event.
// - A round-robin scheduler serialises pending events onto one valid/ready event port (channel index + polarity).
// - Sits between raw board inputs (buttons, strobes) and a single event consumer FSM, so one consumer serves all channels.

---
 rtl/edge_event_arbiter.sv | 179 +++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event front end: synchronises async inputs, latches qualified edges as
// pending events and serialises them round-robin onto a single valid/ready event port.
module edge_event_arbiter #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned IDX_W       = $clog2(N_CH),
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  sig_in,
  input  logic [N_CH-1:0]  en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_ch,
  output logic             evt_pol,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  ovf,
  input  logic [N_CH-1:0]  ovf_clr
);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  localparam logic UseRise = (EDGE_MODE != 1);
  localparam logic UseFall = (EDGE_MODE != 0);

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  sync_last;
  logic [N_CH-1:0]                  dly_q;
  logic [N_CH-1:0]                  rise_q, fall_q;
  logic [N_CH-1:0]                  qual_edge;
  logic [N_CH-1:0]                  pending_q, pending_d;
  logic [N_CH-1:0]                  pend_pol_q, pend_pol_d;
  logic [N_CH-1:0]                  ovf_q, ovf_d;
  logic [N_CH-1:0]                  cand;
  logic [N_CH-1:0]                  load_vec;
  state_e                           state_q;
  logic                             evt_valid_q;
  logic [IDX_W-1:0]                 evt_ch_q;
  logic                             evt_pol_q;
  logic [IDX_W-1:0]                 rr_ptr_q;
  logic [IDX_W-1:0]                 ch_next;
  logic [IDX_W-1:0]                 search_base;
  logic [IDX_W-1:0]                 probe;
  logic [IDX_W-1:0]                 win_idx;
  logic                             win_found;
  logic                             handshake;
  logic                             load;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Edge pulses are registered, adding one cycle between the sync chain and the pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      dly_q  <= sync_last;
      rise_q <= sync_last & ~dly_q;
      fall_q <= ~sync_last & dly_q;
    end
  end

  assign qual_edge = ((rise_q & {N_CH{UseRise}}) | (fall_q & {N_CH{UseFall}})) & en;

  // Disabled channels are never granted, so a flush and a grant cannot collide.
  assign cand      = pending_q & en;
  assign handshake = evt_valid_q & evt_ready;
  assign ch_next   = IDX_W'((32'(evt_ch_q) + 32'd1) % N_CH);
  assign search_base = (state_q == StOffer) ? ch_next : rr_ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      probe = IDX_W'((32'(search_base) + k) % N_CH);
      if (!win_found && cand[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  assign load = win_found & ((state_q == StIdle) | handshake);

  always_comb begin
    load_vec = '0;
    if (load) begin
      load_vec[win_idx] = 1'b1;
    end
  end

  // A new edge on the channel being granted re-arms it; otherwise an edge on a busy channel
  // is dropped and flagged, keeping the older event and its polarity.
  always_comb begin
    pending_d  = pending_q;
    pend_pol_d = pend_pol_q;
    ovf_d      = ovf_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!en[i]) begin
        pending_d[i] = 1'b0;
      end else if (qual_edge[i] && (!pending_q[i] || load_vec[i])) begin
        pending_d[i]  = 1'b1;
        pend_pol_d[i] = rise_q[i];
      end else if (load_vec[i]) begin
        pending_d[i] = 1'b0;
      end

      if (qual_edge[i] && pending_q[i] && !load_vec[i]) begin
        ovf_d[i] = 1'b1;
      end else if (ovf_clr[i]) begin
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      pend_pol_q <= '0;
      ovf_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_pol_q <= pend_pol_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_pol_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            evt_ch_q    <= win_idx;
            evt_pol_q   <= pend_pol_q[win_idx];
            evt_valid_q <= 1'b1;
            state_q     <= StOffer;
          end
        end
        StOffer: begin
          if (handshake) begin
            rr_ptr_q <= ch_next;
            if (load) begin
              evt_ch_q  <= win_idx;
              evt_pol_q <= pend_pol_q[win_idx];
            end else begin
              evt_valid_q <= 1'b0;
              state_q     <= StIdle;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_pol   = evt_pol_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: a rising-only instance plus a both-edges instance.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [3:0] en;
  logic       evt_ready;
  logic [3:0] ovf_clr;

  logic       evt_valid, evt_pol;
  logic [1:0] evt_ch;
  logic [3:0] pending, ovf;

  logic       evt_valid2, evt_pol2;
  logic [1:0] evt_ch2;
  logic [3:0] pending2, ovf2;

  int total;
  int bad;

  edge_event_arbiter #(.N_CH(4), .IDX_W(2), .SYNC_STAGES(2), .EDGE_MODE(0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .en        (en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_pol   (evt_pol),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  edge_event_arbiter #(.N_CH(4), .IDX_W(2), .SYNC_STAGES(2), .EDGE_MODE(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .en        (en),
    .evt_valid (evt_valid2),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch2),
    .evt_pol   (evt_pol2),
    .pending   (pending2),
    .ovf       (ovf2),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    sig_in    = 4'b0000;
    en        = 4'b1111;
    evt_ready = 1'b1;
    ovf_clr   = 4'b0000;
    rst_n     = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset();
    sig_in    = 4'b0000;
    en        = 4'b1111;
    evt_ready = 1'b1;
    ovf_clr   = 4'b0000;
    rst_n     = 1'b0;
    step();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", evt_valid);
    end
    total++;
    if (pending !== 4'b0000 || ovf !== 4'b0000) begin
      bad++; $display("FAIL reset_flags pending=%b ovf=%b want=0000/0000", pending, ovf);
    end
    total++;
    if (evt_ch !== 2'd0 || evt_pol !== 1'b0) begin
      bad++; $display("FAIL reset_evt ch=%0d pol=%b want=0/0", evt_ch, evt_pol);
    end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_rise();
    apply_reset();
    sig_in = 4'b0100;
    repeat (3) step();
    total++;
    if (pending !== 4'b0000) begin
      bad++; $display("FAIL rise_early pending=%b want=0000", pending);
    end
    step();
    total++;
    if (pending !== 4'b0100) begin
      bad++; $display("FAIL rise_pending pending=%b want=0100", pending);
    end
    step();
    total++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_pol !== 1'b1 || pending !== 4'b0000) begin
      bad++;
      $display("FAIL rise_event valid=%b ch=%0d pol=%b pending=%b want=1/2/1/0000",
               evt_valid, evt_ch, evt_pol, pending);
    end
    step();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL rise_done valid=%b want=0", evt_valid);
    end
    sig_in = 4'b0000;
    repeat (6) step();
    total++;
    if (evt_valid !== 1'b0 || pending !== 4'b0000) begin
      bad++; $display("FAIL fall_ignored valid=%b pending=%b want=0/0000", evt_valid, pending);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ch [4];
    exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd2; exp_ch[3] = 2'd3;
    apply_reset();
    sig_in = 4'b1111;
    repeat (4) step();
    total++;
    if (pending !== 4'b1111) begin
      bad++; $display("FAIL b2b_pending pending=%b want=1111", pending);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (evt_valid !== 1'b1 || evt_ch !== exp_ch[i] || evt_pol !== 1'b1) begin
        bad++;
        $display("FAIL b2b_grant%0d valid=%b ch=%0d pol=%b want=1/%0d/1",
                 i, evt_valid, evt_ch, evt_pol, exp_ch[i]);
      end
    end
    step();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end valid=%b want=0", evt_valid);
    end
    sig_in = 4'b0000;
    repeat (4) step();
  endtask

  task automatic test_overflow();
    apply_reset();
    evt_ready = 1'b0;
    sig_in    = 4'b0010;
    repeat (5) step();
    total++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b1 || pending !== 4'b0000) begin
      bad++;
      $display("FAIL ovf_offer valid=%b ch=%0d pol=%b pending=%b want=1/1/1/0000",
               evt_valid, evt_ch, evt_pol, pending);
    end
    // Second rise re-arms the cleared pending flag.
    sig_in = 4'b0000;
    repeat (3) step();
    sig_in = 4'b0010;
    repeat (4) step();
    total++;
    if (pending !== 4'b0010 || ovf !== 4'b0000 || evt_valid !== 1'b1 || evt_ch !== 2'd1) begin
      bad++;
      $display("FAIL ovf_second pending=%b ovf=%b valid=%b ch=%0d want=0010/0000/1/1",
               pending, ovf, evt_valid, evt_ch);
    end
    // Third rise finds the channel busy and is dropped.
    sig_in = 4'b0000;
    repeat (3) step();
    sig_in = 4'b0010;
    repeat (4) step();
    total++;
    if (ovf !== 4'b0010 || pending !== 4'b0010) begin
      bad++; $display("FAIL ovf_set ovf=%b pending=%b want=0010/0010", ovf, pending);
    end
    total++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b1) begin
      bad++; $display("FAIL ovf_stable valid=%b ch=%0d pol=%b want=1/1/1", evt_valid, evt_ch, evt_pol);
    end
    ovf_clr = 4'b0010;
    step();
    ovf_clr = 4'b0000;
    total++;
    if (ovf !== 4'b0000) begin
      bad++; $display("FAIL ovf_clr ovf=%b want=0000", ovf);
    end
    evt_ready = 1'b1;
    step();
    total++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b1 || pending !== 4'b0000) begin
      bad++;
      $display("FAIL ovf_next valid=%b ch=%0d pol=%b pending=%b want=1/1/1/0000",
               evt_valid, evt_ch, evt_pol, pending);
    end
    step();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_drain valid=%b want=0", evt_valid);
    end
    sig_in = 4'b0000;
    repeat (4) step();
  endtask

  task automatic test_both_edges();
    apply_reset();
    sig_in = 4'b1000;
    repeat (4) step();
    sig_in = 4'b0000;
    step();
    total++;
    if (evt_valid2 !== 1'b1 || evt_ch2 !== 2'd3 || evt_pol2 !== 1'b1) begin
      bad++; $display("FAIL both_rise valid=%b ch=%0d pol=%b want=1/3/1", evt_valid2, evt_ch2, evt_pol2);
    end
    step();
    total++;
    if (evt_valid2 !== 1'b0) begin
      bad++; $display("FAIL both_gap valid=%b want=0", evt_valid2);
    end
    repeat (3) step();
    total++;
    if (evt_valid2 !== 1'b1 || evt_ch2 !== 2'd3 || evt_pol2 !== 1'b0) begin
      bad++; $display("FAIL both_fall valid=%b ch=%0d pol=%b want=1/3/0", evt_valid2, evt_ch2, evt_pol2);
    end
    repeat (4) step();
  endtask

  task automatic test_enable();
    apply_reset();
    en     = 4'b1110;
    sig_in = 4'b0001;
    repeat (6) step();
    total++;
    if (pending !== 4'b0000 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL en_masked pending=%b valid=%b want=0000/0", pending, evt_valid);
    end
    en = 4'b1111;
    repeat (2) step();
    total++;
    if (pending !== 4'b0000 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL en_restore pending=%b valid=%b want=0000/0", pending, evt_valid);
    end
    evt_ready = 1'b0;
    sig_in    = 4'b0010;
    repeat (5) step();
    sig_in = 4'b0110;
    repeat (4) step();
    total++;
    if (pending !== 4'b0100 || evt_valid !== 1'b1 || evt_ch !== 2'd1) begin
      bad++;
      $display("FAIL en_setup pending=%b valid=%b ch=%0d want=0100/1/1", pending, evt_valid, evt_ch);
    end
    en = 4'b1011;
    step();
    total++;
    if (pending !== 4'b0000 || evt_valid !== 1'b1 || evt_ch !== 2'd1) begin
      bad++;
      $display("FAIL en_flush pending=%b valid=%b ch=%0d want=0000/1/1", pending, evt_valid, evt_ch);
    end
    en        = 4'b1111;
    evt_ready = 1'b1;
    step();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL en_no_event valid=%b want=0", evt_valid);
    end
    step();
    total++;
    if (evt_valid !== 1'b0 || pending !== 4'b0000) begin
      bad++; $display("FAIL en_quiet valid=%b pending=%b want=0/0000", evt_valid, pending);
    end
    sig_in = 4'b0000;
    repeat (4) step();
  endtask

  task automatic test_reset_mid_offer();
    logic [1:0] exp_ch [3];
    exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd3;
    apply_reset();
    evt_ready = 1'b0;
    sig_in    = 4'b0001;
    repeat (5) step();
    sig_in = 4'b1011;
    repeat (4) step();
    total++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || pending !== 4'b1010) begin
      bad++;
      $display("FAIL rst_setup valid=%b ch=%0d pending=%b want=1/0/1010", evt_valid, evt_ch, pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (evt_valid !== 1'b0 || pending !== 4'b0000 || ovf !== 4'b0000) begin
      bad++;
      $display("FAIL rst_async valid=%b pending=%b ovf=%b want=0/0000/0000", evt_valid, pending, ovf);
    end
    step();
    evt_ready = 1'b1;
    rst_n     = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (evt_valid !== 1'b1 || evt_ch !== exp_ch[i] || evt_pol !== 1'b1) begin
        bad++;
        $display("FAIL rst_grant%0d valid=%b ch=%0d pol=%b want=1/%0d/1",
                 i, evt_valid, evt_ch, evt_pol, exp_ch[i]);
      end
    end
    step();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL rst_drain valid=%b want=0", evt_valid);
    end
    sig_in = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_rise();
    test_back_to_back();
    test_overflow();
    test_both_edges();
    test_enable();
    test_reset_mid_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
